seg7_bin_display: RTL
=====================

// Module: seg7_bin_display
// PURPOSE
//  Parametrised successor of the fixed 3x10-bit LED decode path. Accepts one binary value per
//  valid/ready handshake and converts it serially to BCD (double-dabble, 1 bit/clk).
//  Drives NDIGIT registered 7-segment codes with leading-zero blanking, per-digit DP and overflow.
//  Sits between the counter/control logic and the board LED pins.
// PARAMETERS
//  BIN_W   10  width of binary input (>=4)
//  NDIGIT  4   number of 7-seg digits driven (>=1); BCD register is 4*NDIGIT bits
// PORTS
//  clk       in   1           system clock; all state on rising edge
//  RST       in   1           asynchronous, active-high reset
//  in_valid  in   1           in_bin/lzb_en/dp_mask valid
//  in_ready  out  1           block idle, can accept; accept = in_valid & in_ready
//  in_bin    in   BIN_W       unsigned value to display
//  lzb_en    in   1           1 = blank leading zeros
//  dp_mask   in   NDIGIT      bit i lights DP of digit i (digit 0 = units)
//  seg_out   out  8*NDIGIT    {abcdefg,dp} per digit; digit i at [8*i+7:8*i]; MS digit in MSBs
//  ovf       out  1           registered; 1 = last value exceeded 10^NDIGIT-1
//  done      out  1           1-cycle pulse, same cycle seg_out/ovf update
// BEHAVIOUR
//  Reset (async): state=IDLE, seg_out=0 (all blank), ovf=0, done=0, BCD/shift regs=0.
//  in_ready = (state==IDLE); combinational, so 1 during and right after reset.
//  FSM IDLE -> SHIFT -> LOAD -> IDLE:
//   IDLE:  on accept, latch in_bin to shift reg, lzb_en, dp_mask; ovf_next = (in_bin > 10^NDIGIT-1);
//          clear BCD reg, cnt=0 -> SHIFT. No accept: hold all outputs.
//   SHIFT: each clk, every BCD nibble >=5 gets +3, then {bcd,shift} <<= 1; cnt++.
//          After BIN_W shifts -> LOAD. Input port changes ignored.
//   LOAD:  encode and register seg_out; ovf<=ovf_next; done<=1 -> IDLE.
//  Latency: accept at cycle T -> seg_out/done valid at T+BIN_W+1. Next accept earliest T+BIN_W+2.
//  Max throughput: one value per BIN_W+2 clocks.
//  Encoding (1=segment lit): 0:1111_1100 1:0110_0000 2:1101_1010 3:1111_0010 4:0110_0110
//   5:1011_0110 6:1011_1110 7:1110_0000 8:1111_1110 9:1111_0110 blank:0000_0000 dash:0000_0010.
//   Nibble >9 cannot occur; encoder default = blank.
//  Blanking: lzb_en=1 blanks every digit above the most significant nonzero digit.
//   Digit 0 is never blanked, so value 0 shows "0".
//  DP: seg bit0 |= dp_mask[i], also on blanked digits; dp_mask is ignored on overflow.
//  Overflow: conversion still runs the full BIN_W cycles (fixed latency); LOAD drives every digit
//   to dash and ovf=1. Overflow is impossible when 2^BIN_W <= 10^NDIGIT; compare is then const-0.
//  BCD bits shifted out of the top nibble are discarded. Overflow only shows through ovf/dash.
//  Reset mid-SHIFT/LOAD: conversion aborted, outputs return to reset values, no done pulse.
//  Width rules: cnt is $clog2(BIN_W+1) bits. +3 applies per nibble without carry across nibbles.
//   10^NDIGIT-1 is evaluated as a constant of width max(BIN_W, bits needed), with no truncation.
// STRUCTURE
//  Package seg7_pkg: SEG_BLANK, SEG_DASH, seg7_encode(4b)->8b function,
//   pow10(n) constant function, FSM state enum {IDLE,SHIFT,LOAD}.
//  Sub-module bin2bcd_seq #(BIN_W,NDIGIT): start/busy/bcd_out serial double-dabble core.
//  Top holds the handshake, captures mask/lzb, generates ovf, and does blanking and encode.
// TESTING (BIN_W=10, NDIGIT=4 unless stated)
//  1 Reset pulse -> seg_out=32'h0, ovf=0, done=0, in_ready=1 asynchronously, before next edge.
//  2 in_bin=987, lzb_en=0, dp_mask=0 -> done at accept+11; seg_out=
//    {FC,F6,FE,E0} (0,9,8,7); in_ready low for cycles accept+1..accept+11.
//  3 lzb_en=1: in_bin=0 -> {00,00,00,FC}; in_bin=40 -> {00,00,66,FC};
//    dp_mask=4'b1000, in_bin=5 -> {01,00,00,B6}.
//  4 NDIGIT=3, in_bin=1000 -> ovf=1, seg_out={02,02,02}, done at accept+11;
//    then in_bin=999 -> ovf=0, {F6,F6,F6}.
//  5 in_valid held high, in_bin toggling during SHIFT -> changes ignored;
//    exactly one accept per 12 clocks, each result matches the value captured at its accept.
//  6 RST asserted at accept+5 -> seg_out=0, no done; after release, in_bin=123 converts normally
//    to {FC,60,DA,F2}.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, segment encoder and FSM states
// for the binary-to-7-segment display path.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  // {abcdefg,dp}, dp left clear
  function automatic logic [7:0] seg7_encode(
    input logic [3:0] d
  );
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // wide enough for any digit count the display can use
  function automatic logic [127:0] pow10(
    input int n
  );
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < n; i++)
      p = p * 128'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter:
// one input bit per clock, BIN_W clocks per value.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int NDIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  last,
  output logic [4*NDIGIT-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BW    = 4 * NDIGIT;

  logic [BIN_W-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]    adj;

  assign last = busy && (cnt == CNT_W'(BIN_W - 1));

  // per-nibble +3 when >=5, no carry between nibbles
  always_comb begin
    adj = '0;
    for (int i = 0; i < NDIGIT; i++) begin
      if (bcd_out[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_out[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = bcd_out[4*i +: 4];
    end
  end

  // load on start, then shift {bcd,sh} left once per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      sh      <= bin;
      cnt     <= '0;
      bcd_out <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      {bcd_out, sh} <= {adj, sh} << 1;
      cnt           <= cnt + 1'b1;
      if (last)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_bin_display.sv
// Handshaked binary-to-7-segment display driver with
// leading-zero blanking, per-digit DP and overflow dashes.
module seg7_bin_display
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int NDIGIT = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  input  logic                  lzb_en,
  input  logic [NDIGIT-1:0]     dp_mask,
  output logic [8*NDIGIT-1:0]   seg_out,
  output logic                  ovf,
  output logic                  done
);

  localparam int CW =
    (BIN_W > 4*NDIGIT) ? BIN_W : 4*NDIGIT;
  localparam logic [CW-1:0] MAXV =
    CW'(pow10(NDIGIT) - 128'd1);

  state_t state, state_nx;

  logic                  acc;
  logic                  busy;
  logic                  last;
  logic                  lzb;
  logic                  ovf_nx;
  logic [NDIGIT-1:0]     dp;
  logic [4*NDIGIT-1:0]   bcd;
  logic [8*NDIGIT-1:0]   seg_nx;

  assign in_ready = (state == IDLE);
  assign acc      = in_valid & in_ready;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .NDIGIT (NDIGIT)
  ) u_core (
    .clk     (clk),
    .rst     (RST),
    .start   (acc),
    .bin     (in_bin),
    .busy    (busy),
    .last    (last),
    .bcd_out (bcd)
  );

  // state register
  always_ff @(posedge clk or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next state: accept, shift until the core's last bit, load
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = SHIFT;
      SHIFT:   if (last || !busy) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // capture display options and range check at accept
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      lzb    <= 1'b0;
      dp     <= '0;
      ovf_nx <= 1'b0;
    end else if (acc) begin
      lzb    <= lzb_en;
      dp     <= dp_mask;
      ovf_nx <= CW'(in_bin) > MAXV;
    end
  end

  // blank from the top down until first nonzero digit
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    logic [7:0] code;
    seg_nx = '0;
    lead   = lzb;
    nib    = '0;
    code   = '0;
    for (int i = NDIGIT - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (nib != 4'd0 || i == 0)
        lead = 1'b0;
      code    = lead ? SEG_BLANK : seg7_encode(nib);
      code[0] = code[0] | dp[i];
      if (ovf_nx)
        code = SEG_DASH;
      seg_nx[8*i +: 8] = code;
    end
  end

  // register display outputs in LOAD
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      seg_out <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == LOAD);
      if (state == LOAD) begin
        seg_out <= seg_nx;
        ovf     <= ovf_nx;
      end
    end
  end

endmodule
